tmr_err_monitor: RTL and testbench
==================================

Name: tmr_err_monitor

Overview:
Consumes the `err` outputs of a group of TMR voters and decides whether a disagreement is transient or persistent.
- Counts voter disagreements and keeps a sticky fault flag.
- On a persistent disagreement, requests a resynchronisation of the triplicated registers through a req/ack handshake.
- Sits directly downstream of the voters: each voter `err` pin feeds one `err_in` bit.

Parameters:
- NUM_VOTERS, 4, number of voter `err` lines monitored (≥1).
- CNT_W, 16, width of the error counter (≥4).
- PERSIST_CYCLES, 4, consecutive error cycles that classify a fault as persistent (2..255).
- RESYNC_TIMEOUT, 16, cycles to wait for `resync_ack` before declaring failure (2..255).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- err_in  input  NUM_VOTERS  voter error lines; bit i = voter i disagrees.
- clr  input  1  synchronous clear of counter, sticky flags and FAILED state.
- resync_ack  input  1  resync complete, from the resync controller.
- resync_req  output  1  request resynchronisation of triplicated state.
- err_count  output  CNT_W  saturating count of voter error events.
- fault_sticky  output  1  set on any error; held until clr.
- persistent_mask  output  NUM_VOTERS  voters implicated in the last persistent fault.
- failed  output  1  resync timed out; held until clr.

Behaviour:
- Reset (async, rst_n=0) clears everything:
  - all outputs 0, FSM=IDLE, internal counters 0, input register 0.
- Input stage: err_in is registered once into err_q. Define any_err = |err_q. An error asserted before edge k is in err_q after edge k and acts on state at edge k+1, so it is visible on outputs 2 edges after being driven.
- Counter: each edge adds popcount(err_q) to err_count.
  - Saturates at 2^CNT_W-1; never wraps.
  - Counting continues in every FSM state.
- fault_sticky: set on the edge where any_err=1 is consumed.
- FSM states: IDLE, OBSERVE, RESYNC, COOLDOWN, FAILED.
  - IDLE, any_err=1: go to OBSERVE, run=1, acc=err_q.
  - OBSERVE, any_err=1: run+1, acc|=err_q. When run+1 == PERSIST_CYCLES: go to RESYNC, persistent_mask<=acc|err_q, resync_req<=1, tmo=0.
  - OBSERVE, any_err=0: transient; return to IDLE, run=0, no req.
  - RESYNC: resync_req held high; tmo+1 per cycle.
    - resync_ack=1: resync_req<=0, go to COOLDOWN.
    - Otherwise, tmo+1 == RESYNC_TIMEOUT: resync_req<=0, failed<=1, go to FAILED.
    - ack arriving on the timeout edge: ack wins.
  - COOLDOWN: lasts PERSIST_CYCLES cycles, then IDLE. Errors are counted but never restart OBSERVE, which masks voter glitches while the triplicated state reloads.
  - FAILED: absorbing; left only by clr or reset. Counting continues.
- resync_ack outside RESYNC is ignored.
- clr (synchronous, highest priority after reset), on the edge it is sampled:
  - err_count<=0, fault_sticky<=0, persistent_mask<=0, failed<=0.
  - FSM<=IDLE, resync_req<=0.
  - err_q for that edge is discarded: no count, no FSM action.
  - The input register still samples err_in normally.
- Reset during RESYNC drops resync_req immediately (async).

Optional Feature:
- Macro: TMR_MON_CAPTURE_EN.
- When defined, two extra outputs are present:
  - first_err_vec (NUM_VOTERS): err_q of the first error after reset/clr.
  - first_err_time (CNT_W): value of a free-running, wrapping cycle counter at that moment.
- Capture occurs once and holds until clr or reset; both reset to 0.
- Free-running counter: reset to 0, wraps at 2^CNT_W, unaffected by clr.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Transient: err_in=4'b0010 for 1 cycle.
  - -> err_count=1, fault_sticky=1, FSM returns to IDLE.
  - -> resync_req never asserted, persistent_mask=0.
- Persistent: err_in=4'b0001 for 3 cycles, then 4'b0100 for 1 cycle (PERSIST_CYCLES=4); ack 3 cycles after req.
  - -> resync_req rises, persistent_mask=4'b0101, err_count=4.
  - -> req falls on the ack edge; COOLDOWN for 4 cycles, then IDLE.
- Timeout: persistent fault as above, resync_ack held 0.
  - -> resync_req high for exactly 16 cycles, then failed=1 and req=0.
  - -> clr pulse returns failed=0, FSM=IDLE.
- Saturation: CNT_W=4, err_in=4'b1111 for 5 cycles.
  - -> err_count reaches 15 and holds at 15.
- Simultaneous clr and error: clr on the same edge err_q=4'b0011 is consumed.
  - -> err_count=0, fault_sticky=0 after that edge.
  - -> a further 1-cycle error gives err_count=popcount of that error.
- Reset mid-RESYNC: drop rst_n while resync_req=1.
  - -> resync_req, err_count and persistent_mask go to 0 immediately, without waiting for a clock edge.
  - -> with TMR_MON_CAPTURE_EN, first_err_time and first_err_vec also read 0.

Source files
------------

// File: rtl/tmr_err_monitor.sv
// tmr_err_monitor
//   Watches the err outputs of a group of TMR voters and classifies each
//   disagreement as transient or persistent. Keeps a saturating error-event
//   count and a sticky fault flag. A persistent disagreement triggers a
//   resync_req/resync_ack handshake. If the handshake times out, the block
//   latches a failure.
//
//   Optional build macro TMR_MON_CAPTURE_EN adds first-error capture outputs.
//
// Ports:
//   clk             in   clock, all state changes on posedge
//   rst_n           in   asynchronous active-low reset
//   err_in          in   [NUM_VOTERS] voter error lines, bit i = voter i
//   clr             in   synchronous clear of count, sticky flags, FAILED
//   resync_ack      in   resync complete (only honoured while requesting)
//   resync_req      out  request resynchronisation of triplicated state
//   err_count       out  [CNT_W] saturating count of voter error events
//   fault_sticky    out  set on any consumed error, held until clr
//   persistent_mask out  [NUM_VOTERS] voters implicated in last persistent fault
//   failed          out  resync handshake timed out, held until clr
//   first_err_vec   out  [NUM_VOTERS] (TMR_MON_CAPTURE_EN) first error vector
//   first_err_time  out  [CNT_W] (TMR_MON_CAPTURE_EN) cycle stamp of that error
module tmr_err_monitor #(
  parameter int NUM_VOTERS     = 4,
  parameter int CNT_W          = 16,
  parameter int PERSIST_CYCLES = 4,
  parameter int RESYNC_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_VOTERS-1:0] err_in,
  input  logic                  clr,
  input  logic                  resync_ack,
  output logic                  resync_req,
  output logic [CNT_W-1:0]      err_count,
  output logic                  fault_sticky,
  output logic [NUM_VOTERS-1:0] persistent_mask,
  output logic                  failed
`ifdef TMR_MON_CAPTURE_EN
  ,
  output logic [NUM_VOTERS-1:0] first_err_vec,
  output logic [CNT_W-1:0]      first_err_time
`endif
);

  localparam int PC_W  = $clog2(NUM_VOTERS + 1);
  localparam int SUM_W = CNT_W + PC_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OBSERVE,
    ST_RESYNC,
    ST_COOLDOWN,
    ST_FAILED
  } state_t;

  state_t                state_reg;
  logic [NUM_VOTERS-1:0] err_q_reg;
  logic [NUM_VOTERS-1:0] acc_reg;
  logic [7:0]            run_reg;
  logic [7:0]            tmo_reg;
  logic [7:0]            cool_reg;

  logic                  any_err;
  logic [PC_W-1:0]       pop;
  logic [SUM_W-1:0]      sum;
  logic [CNT_W-1:0]      count_next;

  assign any_err = |err_q_reg;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_VOTERS; i++) begin
      pop = pop + PC_W'(err_q_reg[i]);
    end
  end

  // Add in a wider word so overflow is visible, then clamp to all-ones.
  assign sum        = SUM_W'(err_count) + SUM_W'(pop);
  assign count_next = (|sum[SUM_W-1:CNT_W]) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      err_q_reg       <= '0;
      acc_reg         <= '0;
      run_reg         <= '0;
      tmo_reg         <= '0;
      cool_reg        <= '0;
      resync_req      <= 1'b0;
      err_count       <= '0;
      fault_sticky    <= 1'b0;
      persistent_mask <= '0;
      failed          <= 1'b0;
    end else begin
      // The input register keeps sampling even on a clear edge.
      err_q_reg <= err_in;
      if (clr) begin
        // The err_q consumed on this edge is dropped entirely.
        state_reg       <= ST_IDLE;
        acc_reg         <= '0;
        run_reg         <= '0;
        resync_req      <= 1'b0;
        err_count       <= '0;
        fault_sticky    <= 1'b0;
        persistent_mask <= '0;
        failed          <= 1'b0;
      end else begin
        err_count <= count_next;
        if (any_err) begin
          fault_sticky <= 1'b1;
        end
        case (state_reg)
          ST_IDLE: begin
            if (any_err) begin
              state_reg <= ST_OBSERVE;
              run_reg   <= 8'd1;
              acc_reg   <= err_q_reg;
            end
          end
          ST_OBSERVE: begin
            if (!any_err) begin
              // Error run broke before becoming persistent: transient.
              state_reg <= ST_IDLE;
              run_reg   <= '0;
            end else if (run_reg + 8'd1 == 8'(PERSIST_CYCLES)) begin
              state_reg       <= ST_RESYNC;
              persistent_mask <= acc_reg | err_q_reg;
              resync_req      <= 1'b1;
              tmo_reg         <= '0;
            end else begin
              run_reg <= run_reg + 8'd1;
              acc_reg <= acc_reg | err_q_reg;
            end
          end
          ST_RESYNC: begin
            // An ack on the timeout edge still counts as success.
            if (resync_ack) begin
              resync_req <= 1'b0;
              state_reg  <= ST_COOLDOWN;
              cool_reg   <= '0;
            end else if (tmo_reg + 8'd1 == 8'(RESYNC_TIMEOUT)) begin
              resync_req <= 1'b0;
              failed     <= 1'b1;
              state_reg  <= ST_FAILED;
            end else begin
              tmo_reg <= tmo_reg + 8'd1;
            end
          end
          ST_COOLDOWN: begin
            // Errors here are counted but ignored by the classifier while
            // the triplicated registers reload.
            if (cool_reg + 8'd1 == 8'(PERSIST_CYCLES)) begin
              state_reg <= ST_IDLE;
              cool_reg  <= '0;
            end else begin
              cool_reg <= cool_reg + 8'd1;
            end
          end
          ST_FAILED: begin
            state_reg <= ST_FAILED;
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef TMR_MON_CAPTURE_EN
  logic [CNT_W-1:0] free_cnt_reg;
  logic             captured_reg;

  // Free-running stamp counter is not affected by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_cnt_reg   <= '0;
      captured_reg   <= 1'b0;
      first_err_vec  <= '0;
      first_err_time <= '0;
    end else begin
      free_cnt_reg <= free_cnt_reg + CNT_W'(1);
      if (clr) begin
        captured_reg   <= 1'b0;
        first_err_vec  <= '0;
        first_err_time <= '0;
      end else if (any_err && !captured_reg) begin
        captured_reg   <= 1'b1;
        first_err_vec  <= err_q_reg;
        first_err_time <= free_cnt_reg;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tmr_err_monitor.sv
module tb_tmr_err_monitor;

  logic       clk;
  logic       rst_n;
  logic [3:0] err_in;
  logic       clr;
  logic       resync_ack;
  logic       resync_req;
  logic [15:0] err_count;
  logic       fault_sticky;
  logic [3:0] persistent_mask;
  logic       failed;

  // Narrow-counter instance for the saturation scenario.
  logic [3:0] err_in_s;
  logic       clr_s;
  logic       ack_s;
  logic       req_s;
  logic [3:0] count_s;
  logic       sticky_s;
  logic [3:0] mask_s;
  logic       failed_s;

`ifdef TMR_MON_CAPTURE_EN
  logic [3:0]  first_err_vec;
  logic [15:0] first_err_time;
  logic [3:0]  first_err_vec_s;
  logic [3:0]  first_err_time_s;
`endif

  int checks   = 0;
  int failures = 0;

  tmr_err_monitor #(
    .NUM_VOTERS(4), .CNT_W(16), .PERSIST_CYCLES(4), .RESYNC_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .err_in(err_in),
    .clr(clr),
    .resync_ack(resync_ack),
    .resync_req(resync_req),
    .err_count(err_count),
    .fault_sticky(fault_sticky),
    .persistent_mask(persistent_mask),
    .failed(failed)
`ifdef TMR_MON_CAPTURE_EN
    ,
    .first_err_vec(first_err_vec),
    .first_err_time(first_err_time)
`endif
  );

  tmr_err_monitor #(
    .NUM_VOTERS(4), .CNT_W(4), .PERSIST_CYCLES(4), .RESYNC_TIMEOUT(16)
  ) dut_sat (
    .clk(clk),
    .rst_n(rst_n),
    .err_in(err_in_s),
    .clr(clr_s),
    .resync_ack(ack_s),
    .resync_req(req_s),
    .err_count(count_s),
    .fault_sticky(sticky_s),
    .persistent_mask(mask_s),
    .failed(failed_s)
`ifdef TMR_MON_CAPTURE_EN
    ,
    .first_err_vec(first_err_vec_s),
    .first_err_time(first_err_time_s)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; sample and drive 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // Persistent pattern: 0001 x3 then 0100 x1. Returns just after the edge
  // that raises resync_req (5th edge after the call).
  task automatic drive_persist();
    err_in = 4'b0001;
    step(); step(); step();
    err_in = 4'b0100;
    step();
    err_in = 4'b0000;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; resync_ack = 1'b0; err_in = 4'hF;
    clr_s = 1'b0; ack_s = 1'b0; err_in_s = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({resync_req, fault_sticky, failed} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000", {resync_req, fault_sticky, failed});
    end
    checks++;
    if (err_count !== 16'd0 || persistent_mask !== 4'd0) begin
      failures++;
      $display("FAIL reset_count_mask got=%0d/%b exp=0/0000", err_count, persistent_mask);
    end
    checks++;
    if (count_s !== 4'd0 || {req_s, sticky_s, failed_s} !== 3'b000 || mask_s !== 4'd0) begin
      failures++;
      $display("FAIL reset_sat_inst got=%0d/%b/%b exp=0/000/0000", count_s, {req_s, sticky_s, failed_s}, mask_s);
    end
`ifdef TMR_MON_CAPTURE_EN
    checks++;
    if (first_err_vec !== 4'd0 || first_err_time !== 16'd0 || first_err_vec_s !== 4'd0 || first_err_time_s !== 4'd0) begin
      failures++;
      $display("FAIL reset_capture got=%b/%0d exp=0/0", first_err_vec, first_err_time);
    end
`endif
    err_in = 4'h0; err_in_s = 4'h0;
    rst_n = 1'b1;
    step(); step();
    checks++;
    if (err_count !== 16'd0 || fault_sticky !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got=%0d/%b exp=0/0", err_count, fault_sticky);
    end
    $display("test_reset done count=%0d", err_count);
  endtask

  task automatic test_transient();
    err_in = 4'b0010;
    step();
    err_in = 4'b0000;
    step();
    checks++;
    if (err_count !== 16'd1 || fault_sticky !== 1'b1) begin
      failures++;
      $display("FAIL transient_count got=%0d/%b exp=1/1", err_count, fault_sticky);
    end
    step(); step();
    checks++;
    if (resync_req !== 1'b0 || persistent_mask !== 4'd0 || err_count !== 16'd1) begin
      failures++;
      $display("FAIL transient_noreq got=%b/%b/%0d exp=0/0000/1", resync_req, persistent_mask, err_count);
    end
    // A 3-cycle run from IDLE must not reach persistence; a leftover
    // OBSERVE run from the first glitch would.
    err_in = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) err_in = 4'b0000;
      step();
      checks++;
      if (resync_req !== 1'b0) begin
        failures++;
        $display("FAIL transient_run3_req cycle=%0d got=%b exp=0", i, resync_req);
      end
    end
    checks++;
    if (err_count !== 16'd4) begin
      failures++;
      $display("FAIL transient_run3_count got=%0d exp=4", err_count);
    end
    do_clr();
    $display("test_transient done");
  endtask

  task automatic test_persistent();
    do_clr();
    err_in = 4'b0001;
    step(); step(); step();
    err_in = 4'b0100;
    step();
    checks++;
    if (resync_req !== 1'b0) begin
      failures++;
      $display("FAIL persist_early_req got=%b exp=0", resync_req);
    end
    err_in = 4'b0000;
    step();
    checks++;
    if (resync_req !== 1'b1 || persistent_mask !== 4'b0101 || err_count !== 16'd4) begin
      failures++;
      $display("FAIL persist_req got=%b/%b/%0d exp=1/0101/4", resync_req, persistent_mask, err_count);
    end
    step(); step();
    checks++;
    if (resync_req !== 1'b1) begin
      failures++;
      $display("FAIL persist_req_held got=%b exp=1", resync_req);
    end
    // Ack 3 cycles after req; errors start arriving during COOLDOWN.
    resync_ack = 1'b1;
    err_in = 4'b1000;
    step();
    resync_ack = 1'b0;
    checks++;
    if (resync_req !== 1'b0) begin
      failures++;
      $display("FAIL persist_ack_drop got=%b exp=0", resync_req);
    end
    // 4 cooldown edges ignore errors, then 4 IDLE/OBSERVE edges re-trigger.
    for (int e = 9; e <= 15; e++) begin
      step();
      checks++;
      if (resync_req !== 1'b0) begin
        failures++;
        $display("FAIL cooldown_mask edge=%0d got=%b exp=0", e, resync_req);
      end
    end
    step();
    checks++;
    if (resync_req !== 1'b1 || persistent_mask !== 4'b1000 || err_count !== 16'd12) begin
      failures++;
      $display("FAIL cooldown_retrigger got=%b/%b/%0d exp=1/1000/12", resync_req, persistent_mask, err_count);
    end
    err_in = 4'b0000;
    resync_ack = 1'b1;
    step();
    resync_ack = 1'b0;
    checks++;
    if (resync_req !== 1'b0 || err_count !== 16'd13) begin
      failures++;
      $display("FAIL persist_second_ack got=%b/%0d exp=0/13", resync_req, err_count);
    end
    do_clr();
    $display("test_persistent done");
  endtask

  task automatic test_timeout();
    int high_cycles;
    do_clr();
    drive_persist();
    high_cycles = 0;
    if (resync_req === 1'b1 && failed === 1'b0) high_cycles++;
    for (int i = 0; i < 15; i++) begin
      step();
      if (resync_req === 1'b1 && failed === 1'b0) high_cycles++;
    end
    checks++;
    if (high_cycles !== 16) begin
      failures++;
      $display("FAIL timeout_req_width got=%0d exp=16", high_cycles);
    end
    step();
    checks++;
    if (resync_req !== 1'b0 || failed !== 1'b1) begin
      failures++;
      $display("FAIL timeout_failed got=%b/%b exp=0/1", resync_req, failed);
    end
    // Counting continues while FAILED; late ack is ignored.
    err_in = 4'b0001;
    resync_ack = 1'b1;
    step();
    err_in = 4'b0000;
    resync_ack = 1'b0;
    step();
    checks++;
    if (err_count !== 16'd5 || failed !== 1'b1 || resync_req !== 1'b0) begin
      failures++;
      $display("FAIL failed_counting got=%0d/%b/%b exp=5/1/0", err_count, failed, resync_req);
    end
    do_clr();
    checks++;
    if (failed !== 1'b0 || err_count !== 16'd0 || fault_sticky !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clr got=%b/%0d/%b exp=0/0/0", failed, err_count, fault_sticky);
    end
    // Back in IDLE: a fresh persistent run raises req on schedule.
    drive_persist();
    checks++;
    if (resync_req !== 1'b1 || persistent_mask !== 4'b0101) begin
      failures++;
      $display("FAIL timeout_idle_again got=%b/%b exp=1/0101", resync_req, persistent_mask);
    end
    resync_ack = 1'b1;
    step();
    resync_ack = 1'b0;
    do_clr();
    $display("test_timeout done");
  endtask

  task automatic test_clr_collision();
    err_in = 4'b1000;
    step();
    err_in = 4'b0000;
    step(); step();
    checks++;
    if (err_count !== 16'd1 || fault_sticky !== 1'b1) begin
      failures++;
      $display("FAIL collision_pre got=%0d/%b exp=1/1", err_count, fault_sticky);
    end
    err_in = 4'b0011;
    step();
    clr = 1'b1;
    err_in = 4'b0110;
    step();
    clr = 1'b0;
    err_in = 4'b0000;
    checks++;
    if (err_count !== 16'd0 || fault_sticky !== 1'b0 || persistent_mask !== 4'd0) begin
      failures++;
      $display("FAIL collision_clr got=%0d/%b/%b exp=0/0/0000", err_count, fault_sticky, persistent_mask);
    end
    step();
    checks++;
    if (err_count !== 16'd2 || fault_sticky !== 1'b1 || resync_req !== 1'b0) begin
      failures++;
      $display("FAIL collision_after got=%0d/%b/%b exp=2/1/0", err_count, fault_sticky, resync_req);
    end
    step();
    do_clr();
    $display("test_clr_collision done");
  endtask

  task automatic test_saturation();
    logic [3:0] exp_cnt [5];
    exp_cnt = '{4'd4, 4'd8, 4'd12, 4'd15, 4'd15};
    err_in_s = 4'hF;
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) err_in_s = 4'h0;
      step();
      checks++;
      if (count_s !== exp_cnt[i]) begin
        failures++;
        $display("FAIL sat_count step=%0d got=%0d exp=%0d", i, count_s, exp_cnt[i]);
      end
      if (i == 3) err_in_s = 4'h0;
    end
    step(); step();
    checks++;
    if (count_s !== 4'd15 || sticky_s !== 1'b1) begin
      failures++;
      $display("FAIL sat_hold got=%0d/%b exp=15/1", count_s, sticky_s);
    end
    checks++;
    if (req_s !== 1'b1 || mask_s !== 4'hF || failed_s !== 1'b0) begin
      failures++;
      $display("FAIL sat_resync got=%b/%b/%b exp=1/1111/0", req_s, mask_s, failed_s);
    end
    $display("test_saturation done count=%0d", count_s);
  endtask

  task automatic test_reset_mid_resync();
    do_clr();
    drive_persist();
    checks++;
    if (resync_req !== 1'b1 || err_count !== 16'd4) begin
      failures++;
      $display("FAIL midrst_pre got=%b/%0d exp=1/4", resync_req, err_count);
    end
`ifdef TMR_MON_CAPTURE_EN
    checks++;
    if (first_err_vec !== 4'b0001) begin
      failures++;
      $display("FAIL capture_vec got=%b exp=0001", first_err_vec);
    end
`endif
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (resync_req !== 1'b0 || err_count !== 16'd0 || persistent_mask !== 4'd0) begin
      failures++;
      $display("FAIL midrst_async got=%b/%0d/%b exp=0/0/0000", resync_req, err_count, persistent_mask);
    end
`ifdef TMR_MON_CAPTURE_EN
    checks++;
    if (first_err_vec !== 4'd0 || first_err_time !== 16'd0) begin
      failures++;
      $display("FAIL midrst_capture got=%b/%0d exp=0/0", first_err_vec, first_err_time);
    end
`endif
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (resync_req !== 1'b0 || failed !== 1'b0 || fault_sticky !== 1'b0) begin
      failures++;
      $display("FAIL midrst_release got=%b/%b/%b exp=0/0/0", resync_req, failed, fault_sticky);
    end
    $display("test_reset_mid_resync done");
  endtask

  initial begin
    test_reset();
    test_transient();
    test_persistent();
    test_timeout();
    test_clr_collision();
    test_saturation();
    test_reset_mid_resync();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
